// File: rtl/bram_stream_ctrl_if.sv
// Request/response stream bundle between a fabric producer/consumer and bram_stream_ctrl.
// master = user logic issuing writes/reads, slave = the controller.
interface bram_stream_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_addr_in;
    logic [15:0] wr_data_in;

    logic        rd_valid;
    logic        rd_ready;
    logic [9:0]  rd_addr_in;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;

    modport master (
        output wr_valid, wr_addr_in, wr_data_in, rd_valid, rd_addr_in, rsp_ready,
        input  wr_ready, rd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  wr_valid, wr_addr_in, wr_data_in, rd_valid, rd_addr_in, rsp_ready,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/bram_stream_ctrl.sv
// Drives one BlockRAM_1KB from valid/ready write and read streams, packing the wr_data
// side-band fields and returning read data through a credit-limited response FIFO.
module bram_stream_ctrl #(
    parameter int READ_ADDRESS_MSB_FROM_DATALSB  = 24,
    parameter int WRITE_ADDRESS_MSB_FROM_DATALSB = 16,
    parameter int WRITE_ENABLE_FROM_DATA         = 20,
    parameter int RESP_DEPTH                     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_width,
    input  logic              cfg_reg,
    bram_stream_ctrl_if.slave strm,
    output logic [7:0]        bram_wr_addr,
    output logic [31:0]       bram_wr_data,
    output logic [7:0]        bram_rd_addr,
    input  logic [31:0]       bram_rd_data,
    output logic              busy
);
    localparam int RS    = READ_ADDRESS_MSB_FROM_DATALSB;
    localparam int WS    = WRITE_ADDRESS_MSB_FROM_DATALSB;
    localparam int WE    = WRITE_ENABLE_FROM_DATA;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1) + 1;
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [7:0]  wr_word, rd_word;
    logic [1:0]  wr_sel, rd_sel;
    logic        hazard, wr_fire, rd_fire;
    logic [31:0] wd_next;

    logic        rd_pres, rd_s1, rd_s2, cap_valid, cap_now;
    logic [15:0] cap_data, cap_word;
    logic [15:0] unused_rd_hi;

    logic [15:0]      stor_mem [RESP_DEPTH];
    logic [PTR_W-1:0] stor_rd_ptr, stor_wr_ptr;
    logic [CNT_W-1:0] stor_cnt, total_cnt;
    logic             pop, stor_push, stor_pop, head_load;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // 16-bit mode: word = a[8:1], sel = a[0]; 8-bit mode: word = a[9:2], sel = a[1:0].
    always_comb begin
        wr_word = cfg_width ? strm.wr_addr_in[9:2] : strm.wr_addr_in[8:1];
        rd_word = cfg_width ? strm.rd_addr_in[9:2] : strm.rd_addr_in[8:1];
        wr_sel  = cfg_width ? strm.wr_addr_in[1:0] : {1'b0, strm.wr_addr_in[0]};
        rd_sel  = cfg_width ? strm.rd_addr_in[1:0] : {1'b0, strm.rd_addr_in[0]};
    end

    assign hazard    = strm.wr_valid && strm.rd_valid && (wr_word == rd_word);
    assign total_cnt = CNT_W'(rd_pres) + CNT_W'(rd_s1) + CNT_W'(rd_s2) + CNT_W'(cap_valid)
                     + CNT_W'(strm.rsp_valid) + stor_cnt;

    assign strm.wr_ready = !rst;
    assign strm.rd_ready = !rst && !hazard && (total_cnt < CNT_W'(RESP_DEPTH));
    assign wr_fire       = strm.wr_valid && strm.wr_ready;
    assign rd_fire       = strm.rd_valid && strm.rd_ready;
    assign busy          = (total_cnt != '0);

    // The read-select field persists across cycles; everything else is rebuilt per write.
    always_comb begin
        // NOTE: start from a full default so no path leaves wd_next unassigned (no latch).
        wd_next          = '0;
        wd_next[RS +: 2] = rd_fire ? rd_sel : bram_wr_data[RS +: 2];
        if (wr_fire) begin
            wd_next[15:0]    = cfg_width ? {8'h00, strm.wr_data_in[7:0]} : strm.wr_data_in;
            wd_next[WS +: 2] = wr_sel;
            wd_next[WE]      = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_wr_addr <= '0;
            bram_wr_data <= '0;
            bram_rd_addr <= '0;
        end else begin
            bram_wr_data <= wd_next;
            if (wr_fire) bram_wr_addr <= wr_word;
            if (rd_fire) bram_rd_addr <= rd_word;
        end
    end

    // Read tracking: presentation cycle, then one or two cycles of BlockRAM latency.
    assign cap_now      = cfg_reg ? rd_s2 : rd_s1;
    assign cap_word     = cfg_width ? {8'h00, bram_rd_data[7:0]} : bram_rd_data[15:0];
    assign unused_rd_hi = bram_rd_data[31:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pres   <= 1'b0;
            rd_s1     <= 1'b0;
            rd_s2     <= 1'b0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            rd_pres   <= rd_fire;
            rd_s1     <= rd_pres;
            rd_s2     <= rd_s1 && cfg_reg;
            cap_valid <= cap_now;
            if (cap_now) cap_data <= cap_word;
        end
    end

    // Response FIFO: rsp_valid/rsp_data are the head register, stor_mem holds the entries behind it.
    assign pop       = strm.rsp_valid && strm.rsp_ready;
    assign stor_push = cap_valid && strm.rsp_valid && (!pop || (stor_cnt != '0));
    assign stor_pop  = pop && (stor_cnt != '0);
    assign head_load = cap_valid && !stor_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            strm.rsp_valid <= 1'b0;
            strm.rsp_data  <= '0;
            stor_rd_ptr    <= '0;
            stor_wr_ptr    <= '0;
            stor_cnt       <= '0;
        end else begin
            if (stor_pop) begin
                strm.rsp_data <= stor_mem[stor_rd_ptr];
                stor_rd_ptr   <= next_ptr(stor_rd_ptr);
            end else if (head_load) begin
                strm.rsp_data <= cap_data;
            end
            strm.rsp_valid <= stor_pop || head_load || (strm.rsp_valid && !pop);
            if (stor_push) stor_wr_ptr <= next_ptr(stor_wr_ptr);
            stor_cnt <= stor_cnt + CNT_W'(stor_push) - CNT_W'(stor_pop);
        end
    end

    // NOTE: storage array has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (stor_push) stor_mem[stor_wr_ptr] <= cap_data;
    end
endmodule
